// File: rtl/adc_sar_scan_fsm_pkg.sv
// Shared definitions for the SAR ADC scan controller.
// Contents: FSM state encoding, scan mode constants and the
// resolution clamp helper used by the SAR register.
package adc_sar_scan_fsm_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAMPLE  = 3'd1,
        S_CONVERT = 3'd2,
        S_STORE   = 3'd3
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_CONT   = 2'b10;

    // A resolution of 0 or above the converter width means full width.
    function automatic int eff_nbits(input int nb, input int n);
        return (nb == 0 || nb > n) ? n : nb;
    endfunction

endpackage

// File: rtl/adc_sar_scan_fsm_if.sv
// Result port of the SAR ADC scan controller.
// master (controller): result, result_ch, result_valid, overrun out; result_ready in.
// slave  (consumer)  : the mirror image.
interface adc_sar_scan_fsm_if #(
    parameter int N    = 8,
    parameter int CH_W = 2
);
    logic [N-1:0]    result;
    logic [CH_W-1:0] result_ch;
    logic            result_valid;
    logic            result_ready;
    logic            overrun;

    modport master (
        output result, result_ch, result_valid, overrun,
        input  result_ready
    );

    modport slave (
        input  result, result_ch, result_valid, overrun,
        output result_ready
    );
endinterface

// File: rtl/adc_sar_reg.sv
// Successive-approximation register for the SAR ADC controller.
// Ports: clk, rst (sync, active high), enable (clock enable),
//        clear (drop code to zero), init (load MSB trial), step (resolve
//        one bit using comp), nbits (requested resolution, clamped here),
//        dac_code (trial code, MSB aligned), done (current step is the last).
module adc_sar_reg
    import adc_sar_scan_fsm_pkg::*;
#(
    parameter int N    = 8,
    parameter int NB_W = $clog2(N + 1)
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            clear,
    input  logic            init,
    input  logic            step,
    input  logic            comp,
    input  logic [NB_W-1:0] nbits,
    output logic [N-1:0]    dac_code,
    output logic            done
);
    localparam logic [N-1:0] MSB_ONE = N'(1) << (N - 1);

    logic [N-1:0]    trial;
    logic [NB_W-1:0] remaining;
    logic [NB_W-1:0] nb_eff;

    assign nb_eff = NB_W'(eff_nbits(int'(nbits), N));
    assign done   = (remaining == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_code  <= '0;
            trial     <= '0;
            remaining <= '0;
        end else if (enable) begin
            if (clear) begin
                dac_code  <= '0;
                trial     <= '0;
                remaining <= '0;
            end else if (init) begin
                dac_code  <= MSB_ONE;
                trial     <= MSB_ONE;
                remaining <= nb_eff - NB_W'(1);
            end else if (step) begin
                // Keep or drop the bit under trial; the final step sets no
                // further bit so everything below the resolution stays zero.
                dac_code <= (comp ? dac_code : (dac_code & ~trial))
                          | (done ? '0 : (trial >> 1));
                trial    <= trial >> 1;
                if (!done) begin
                    remaining <= remaining - NB_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/adc_sar_scan_fsm.sv
// SAR ADC scan controller: sampling, bit cycling via adc_sar_reg,
// single / one-shot scan / continuous scan sequencing and result delivery.
// Ports: clk, rst (sync, active high), enable, soc, rdy, abort, mode,
//        ch_first, ch_last, nbits, sample_cycles, comp (analog side in);
//        current_state, sample, ch_sel, dac_code, eoc_it, eos_it, busy out;
//        res: result port (master modport).
//
// state     | meaning
// S_IDLE    | waiting for soc with rdy
// S_SAMPLE  | sampling switch closed for sample_cycles+1 cycles
// S_CONVERT | one bit resolved per cycle, nbits cycles
// S_STORE   | result written, next channel or back to idle
module adc_sar_scan_fsm
    import adc_sar_scan_fsm_pkg::*;
#(
    parameter int N          = 8,
    parameter int NCH        = 4,
    parameter int CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int SMP_W      = 3,
    parameter int STATE_SIZE = 3
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    soc,
    input  logic                    rdy,
    input  logic                    abort,
    input  logic [1:0]              mode,
    input  logic [CH_W-1:0]         ch_first,
    input  logic [CH_W-1:0]         ch_last,
    input  logic [$clog2(N+1)-1:0]  nbits,
    input  logic [SMP_W-1:0]        sample_cycles,
    input  logic                    comp,
    output logic [STATE_SIZE-1:0]   current_state,
    output logic                    sample,
    output logic [CH_W-1:0]         ch_sel,
    output logic [N-1:0]            dac_code,
    output logic                    eoc_it,
    output logic                    eos_it,
    output logic                    busy,
    adc_sar_scan_fsm_if.master      res
);
    localparam int NB_W = $clog2(N + 1);

    state_t            state, state_nxt;
    logic [SMP_W-1:0]  smp_cnt;
    logic [1:0]        mode_q;
    logic [CH_W-1:0]   ch_first_q, ch_last_q;
    logic [NB_W-1:0]   nbits_q;
    logic [SMP_W-1:0]  smp_q;
    logic [N-1:0]      result_q;
    logic [CH_W-1:0]   result_ch_q;
    logic              result_valid_q, overrun_q;
    logic              sar_done, sar_init, sar_step;
    logic              is_single, at_last;
    logic [CH_W-1:0]   ch_next;

    assign is_single = (mode_q != MODE_SCAN) && (mode_q != MODE_CONT);
    assign at_last   = (ch_sel == ch_last_q);
    assign ch_next   = (ch_sel == CH_W'(NCH - 1)) ? '0 : ch_sel + CH_W'(1);
    assign sar_init  = (state == S_SAMPLE) && (smp_cnt == '0) && !abort;
    assign sar_step  = (state == S_CONVERT) && !abort;

    adc_sar_reg #(.N(N), .NB_W(NB_W)) u_sar (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clear    (abort),
        .init     (sar_init),
        .step     (sar_step),
        .comp     (comp),
        .nbits    (nbits_q),
        .dac_code (dac_code),
        .done     (sar_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (enable) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (soc && rdy) state_nxt = S_SAMPLE;
                S_SAMPLE:  if (smp_cnt == '0) state_nxt = S_CONVERT;
                S_CONVERT: if (sar_done) state_nxt = S_STORE;
                S_STORE:   state_nxt = (is_single || (at_last && mode_q == MODE_SCAN))
                                       ? S_IDLE : S_SAMPLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        current_state = STATE_SIZE'(state);
        sample        = (state == S_SAMPLE);
        busy          = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_cnt        <= '0;
            mode_q         <= '0;
            ch_first_q     <= '0;
            ch_last_q      <= '0;
            nbits_q        <= '0;
            smp_q          <= '0;
            ch_sel         <= '0;
            result_q       <= '0;
            result_ch_q    <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            eoc_it         <= 1'b0;
            eos_it         <= 1'b0;
        end else if (!enable) begin
            overrun_q <= 1'b0;
            eoc_it    <= 1'b0;
            eos_it    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            eoc_it    <= 1'b0;
            eos_it    <= 1'b0;
            if (result_valid_q && res.result_ready) begin
                result_valid_q <= 1'b0;
            end
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (soc && rdy) begin
                            mode_q     <= (mode == 2'b11) ? MODE_SINGLE : mode;
                            ch_first_q <= ch_first;
                            ch_last_q  <= ch_last;
                            nbits_q    <= nbits;
                            smp_q      <= sample_cycles;
                            ch_sel     <= ch_first;
                            smp_cnt    <= sample_cycles;
                        end
                    end
                    S_SAMPLE: begin
                        if (smp_cnt != '0) begin
                            smp_cnt <= smp_cnt - SMP_W'(1);
                        end
                    end
                    S_STORE: begin
                        // Store overrides a same-edge handshake clear.
                        result_q       <= dac_code;
                        result_ch_q    <= ch_sel;
                        result_valid_q <= 1'b1;
                        eoc_it         <= 1'b1;
                        overrun_q      <= result_valid_q && !res.result_ready;
                        if (!is_single) begin
                            smp_cnt <= smp_q;
                            if (at_last) begin
                                eos_it <= 1'b1;
                                ch_sel <= ch_first_q;
                            end else begin
                                ch_sel <= ch_next;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign res.result       = result_q;
    assign res.result_ch    = result_ch_q;
    assign res.result_valid = result_valid_q;
    assign res.overrun      = overrun_q;
endmodule

// File: tb/tb_adc_sar_scan_fsm.sv
module tb_adc_sar_scan_fsm;
    typedef struct {
        int         cyc;
        logic [7:0] code;
        logic [1:0] ch;
        bit         eos;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1, soc = 1'b0, rdy = 1'b1, abort = 1'b0;
    logic [1:0] mode = 2'b00, ch_first = 2'd0, ch_last = 2'd0;
    logic [3:0] nbits = 4'd8;
    logic [2:0] sample_cycles = 3'd0;
    logic       comp;
    logic [2:0] current_state;
    logic       sample, eoc_it, eos_it, busy;
    logic [1:0] ch_sel;
    logic [7:0] dac_code;
    logic [7:0] vin [4];

    adc_sar_scan_fsm_if #(.N(8), .CH_W(2)) rif ();

    adc_sar_scan_fsm #(.N(8), .NCH(4), .CH_W(2), .SMP_W(3), .STATE_SIZE(3)) dut (
        .clk(clk), .rst(rst), .enable(enable), .soc(soc), .rdy(rdy), .abort(abort),
        .mode(mode), .ch_first(ch_first), .ch_last(ch_last), .nbits(nbits),
        .sample_cycles(sample_cycles), .comp(comp), .current_state(current_state),
        .sample(sample), .ch_sel(ch_sel), .dac_code(dac_code), .eoc_it(eoc_it),
        .eos_it(eos_it), .busy(busy), .res(rif)
    );

    // Ideal comparator: each channel carries a fixed input code.
    assign comp = (vin[ch_sel] >= dac_code);

    always #5 clk = ~clk;

    int  n_cmp = 0, n_bad = 0;
    int  cyc = 0;
    bit  e_rst, e_en, e_rdy;
    ev_t evq[$];
    bit  mvalid = 0;
    logic [7:0] mres = '0;
    logic [1:0] mch = '0;
    int  sample_cnt = 0, eoc_cnt = 0, eos_cnt = 0, ovr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Ideal SAR outcome: the top nb bits of the input code.
    function automatic logic [7:0] exp_code(input logic [7:0] v, input int nb);
        int n;
        logic [7:0] mask;
        n = (nb == 0 || nb > 8) ? 8 : nb;
        mask = 8'hFF << (8 - n);
        return v & mask;
    endfunction

    task automatic push(input int c, input logic [7:0] code, input logic [1:0] ch, input bit eos);
        ev_t e;
        e.cyc = c; e.code = code; e.ch = ch; e.eos = eos;
        evq.push_back(e);
    endtask

    always @(posedge clk) begin
        cyc++;
        e_rst = rst;
        e_en  = enable;
        e_rdy = rif.result_ready;
    end

    // Per-cycle comparison against the transaction model.
    always @(negedge clk) begin
        bit hit, x_eoc, x_eos, x_ovr;
        if (cyc > 0) begin
            hit = (evq.size() > 0) && (evq[0].cyc == cyc);
            x_eoc = 0; x_eos = 0; x_ovr = 0;
            if (e_rst) begin
                mvalid = 0; mres = '0; mch = '0;
            end else if (e_en) begin
                if (hit) begin
                    x_eoc = 1;
                    x_eos = evq[0].eos;
                    x_ovr = mvalid && !e_rdy;
                    mvalid = 1; mres = evq[0].code; mch = evq[0].ch;
                end else if (mvalid && e_rdy) begin
                    mvalid = 0;
                end
            end
            if (hit) void'(evq.pop_front());
            chk("eoc_it", 32'(eoc_it), 32'(x_eoc));
            chk("eos_it", 32'(eos_it), 32'(x_eos));
            chk("overrun", 32'(rif.overrun), 32'(x_ovr));
            chk("result_valid", 32'(rif.result_valid), 32'(mvalid));
            chk("result", 32'(rif.result), 32'(mres));
            chk("result_ch", 32'(rif.result_ch), 32'(mch));
            if (sample) sample_cnt++;
            if (eoc_it) eoc_cnt++;
            if (eos_it) eos_cnt++;
            if (rif.overrun) ovr_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic start(input logic [1:0] m, input logic [1:0] cf, input logic [1:0] cl,
                         input logic [3:0] nb, input logic [2:0] sc, output int e0);
        mode = m; ch_first = cf; ch_last = cl; nbits = nb; sample_cycles = sc;
        soc = 1'b1;
        e0 = cyc + 1;
        tick(1);
        soc = 1'b0;
    endtask

    initial begin
        int e0;
        logic [2:0] st_hold;
        logic [7:0] dc_hold;
        rif.result_ready = 1'b0;
        vin[0] = 8'h00; vin[1] = 8'h00; vin[2] = 8'h00; vin[3] = 8'h00;
        tick(3);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dac", 32'(dac_code), 32'd0);
        chk("rst_ch_sel", 32'(ch_sel), 32'd0);
        chk("rst_result", 32'(rif.result), 32'd0);

        // soc with the analog core not ready is ignored
        rdy = 1'b0; soc = 1'b1; tick(1); soc = 1'b0; rdy = 1'b1; tick(1);
        chk("soc_rdy_low", 32'(busy), 32'd0);

        // single conversion, full resolution
        vin[2] = 8'hA5;
        sample_cnt = 0; eoc_cnt = 0; eos_cnt = 0;
        start(2'b00, 2'd2, 2'd2, 4'd8, 3'd0, e0);
        push(e0 + 10, exp_code(vin[2], 8), 2'd2, 0);
        wait_until(e0 + 12);
        chk("t1_result", 32'(rif.result), 32'hA5);
        chk("t1_result_ch", 32'(rif.result_ch), 32'd2);
        chk("t1_valid", 32'(rif.result_valid), 32'd1);
        chk("t1_sample_cycles", 32'(sample_cnt), 32'd1);
        chk("t1_eoc_count", 32'(eoc_cnt), 32'd1);
        chk("t1_eos_count", 32'(eos_cnt), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // reduced resolution, clamped resolution, 1-bit resolution
        rif.result_ready = 1'b1; tick(1);
        start(2'b00, 2'd2, 2'd2, 4'd4, 3'd2, e0);
        push(e0 + 8, exp_code(vin[2], 4), 2'd2, 0);
        wait_until(e0 + 10);
        chk("t2_nbits4", 32'(rif.result), 32'hA0);
        start(2'b11, 2'd2, 2'd2, 4'd0, 3'd0, e0);
        push(e0 + 10, exp_code(vin[2], 0), 2'd2, 0);
        wait_until(e0 + 12);
        chk("t2_nbits0", 32'(rif.result), 32'hA5);
        start(2'b00, 2'd2, 2'd2, 4'd1, 3'd1, e0);
        push(e0 + 4, exp_code(vin[2], 1), 2'd2, 0);
        wait_until(e0 + 6);
        chk("t2_nbits1", 32'(rif.result), 32'h80);

        // one-shot scan through the channel wrap: 3, 0, 1
        vin[3] = 8'h3C; vin[0] = 8'h81; vin[1] = 8'h5A;
        eoc_cnt = 0; eos_cnt = 0;
        start(2'b01, 2'd3, 2'd1, 4'd8, 3'd1, e0);
        push(e0 + 11, exp_code(vin[3], 8), 2'd3, 0);
        push(e0 + 22, exp_code(vin[0], 8), 2'd0, 0);
        push(e0 + 33, exp_code(vin[1], 8), 2'd1, 1);
        mode = 2'b00; ch_last = 2'd3;
        tick(5);
        soc = 1'b1; tick(1); soc = 1'b0;
        wait_until(e0 + 36);
        chk("t3_eoc_count", 32'(eoc_cnt), 32'd3);
        chk("t3_eos_count", 32'(eos_cnt), 32'd1);
        chk("t3_last_result", 32'(rif.result), 32'h5A);
        chk("t3_last_ch", 32'(rif.result_ch), 32'd1);
        chk("t3_idle", 32'(busy), 32'd0);

        // continuous scan with consumer stalled, then abort
        vin[0] = 8'h11; vin[1] = 8'h22;
        rif.result_ready = 1'b0;
        eoc_cnt = 0; ovr_cnt = 0;
        start(2'b10, 2'd0, 2'd1, 4'd8, 3'd0, e0);
        push(e0 + 10, exp_code(vin[0], 8), 2'd0, 0);
        push(e0 + 20, exp_code(vin[1], 8), 2'd1, 1);
        push(e0 + 30, exp_code(vin[0], 8), 2'd0, 0);
        wait_until(e0 + 29);
        rif.result_ready = 1'b1;
        wait_until(e0 + 30);
        rif.result_ready = 1'b0;
        chk("t4_store_wins", 32'(rif.result_valid), 32'd1);
        chk("t4_overruns", 32'(ovr_cnt), 32'd1);
        wait_until(e0 + 34);
        abort = 1'b1;
        wait_until(e0 + 35);
        abort = 1'b0;
        chk("t4_abort_idle", 32'(busy), 32'd0);
        chk("t4_abort_dac", 32'(dac_code), 32'd0);
        chk("t4_abort_valid", 32'(rif.result_valid), 32'd1);
        chk("t4_abort_result", 32'(rif.result), 32'h11);
        tick(15);
        chk("t4_eoc_count", 32'(eoc_cnt), 32'd3);

        // enable held low for 5 cycles during conversion
        rif.result_ready = 1'b1;
        vin[1] = 8'hC3;
        start(2'b00, 2'd1, 2'd1, 4'd8, 3'd0, e0);
        push(e0 + 15, exp_code(vin[1], 8), 2'd1, 0);
        wait_until(e0 + 3);
        st_hold = current_state; dc_hold = dac_code;
        enable = 1'b0;
        wait_until(e0 + 8);
        chk("t5_state_frozen", 32'(current_state), 32'(st_hold));
        chk("t5_dac_frozen", 32'(dac_code), 32'(dc_hold));
        chk("t5_busy", 32'(busy), 32'd1);
        enable = 1'b1;
        wait_until(e0 + 17);
        chk("t5_result", 32'(rif.result), 32'hC3);

        // reset while sampling
        eoc_cnt = 0;
        start(2'b00, 2'd3, 2'd3, 4'd8, 3'd3, e0);
        wait_until(e0 + 2);
        chk("t6_sampling", 32'(sample), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_sample", 32'(sample), 32'd0);
        chk("t6_dac", 32'(dac_code), 32'd0);
        chk("t6_ch_sel", 32'(ch_sel), 32'd0);
        chk("t6_result", 32'(rif.result), 32'd0);
        tick(15);
        chk("t6_no_eoc", 32'(eoc_cnt), 32'd0);

        chk("pending_events", 32'(evq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adc_sar_scan_fsm.md
Name: adc_sar_scan_fsm

Overview:
Successor SAR ADC controller. Adds configurable resolution, programmable sampling length, multi-channel scan sequencing (single, one-shot scan, continuous scan) and the SAR bit-cycling register. Delivers results through a valid/ready result port with overrun flagging. Sits between the register bank / trigger logic and the analog SAR core (sampling switch, DAC, comparator).

Parameters:
N, 8, maximum resolution in bits (width of dac_code/result)
NCH, 4, number of analog channels
CH_W, 2, channel index width (clog2(NCH), min 1)
SMP_W, 3, sample-length field width
STATE_SIZE, 3, state register width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  clock enable; low freezes all registers, pulses forced low
soc  in  1  start of conversion; honoured only in S_IDLE
rdy  in  1  analog core ready; soc ignored while low
abort  in  1  cancel current operation
mode  in  2  00 single channel, 01 one-shot scan, 10 continuous scan, 11 treated as 00
ch_first  in  CH_W  first/only channel
ch_last  in  CH_W  last scan channel
nbits  in  clog2(N+1)  resolution 1..N
sample_cycles  in  SMP_W  extra sampling cycles (sampling lasts sample_cycles+1)
comp  in  1  comparator: 1 = vin >= DAC, keep trial bit
current_state  out  STATE_SIZE  FSM state
sample  out  1  sampling switch, high in S_SAMPLE
ch_sel  out  CH_W  mux select for channel being converted
dac_code  out  N  SAR trial code to DAC, MSB-aligned
result  out  N  converted code, MSB-aligned, low N-nbits bits zero
result_ch  out  CH_W  channel of result
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
overrun  out  1  one-cycle pulse: unread result overwritten
eoc_it  out  1  one-cycle pulse per completed conversion
eos_it  out  1  one-cycle pulse at end of scan sequence
busy  out  1  current_state != S_IDLE

Behaviour:
- Reset: state S_IDLE; ch_sel, dac_code, result, result_ch, result_valid, overrun, eoc_it, eos_it, counters, shadow config all 0.
- enable low: hold everything; overrun/eoc_it/eos_it low; result_ready handshake also frozen.
- Config (mode, ch_first, ch_last, nbits, sample_cycles) latched into shadow regs on S_IDLE->S_SAMPLE; later changes ignored until next soc. nbits of 0 or >N clamps to N.
- S_IDLE: soc && rdy -> S_SAMPLE, ch_sel<=ch_first, smp_cnt<=sample_cycles.
- S_SAMPLE: sample=1; smp_cnt decrements; at smp_cnt==0 -> S_CONVERT, dac_code<=1<<(N-1), bit_idx<=N-1.
- S_CONVERT: per cycle, bit_idx cleared if comp==0; if step count < nbits, next lower bit set. After nbits cycles -> S_STORE. Bits below N-nbits never set.
- S_STORE (1 cycle): result<=dac_code, result_ch<=ch_sel, result_valid<=1, eoc_it<=1; overrun<=1 if result_valid && !result_ready at that edge. Next:
  - mode 00/11 -> S_IDLE.
  - ch_sel==ch_last: eos_it<=1; mode 01 -> S_IDLE; mode 10 -> S_SAMPLE with ch_sel<=ch_first.
  - otherwise -> S_SAMPLE, ch_sel<=ch_sel+1, wrapping NCH-1->0. ch_first>ch_last therefore scans through the wrap.
- Latency: result_valid rises sample_cycles+nbits+2 cycles after the edge sampling soc.
- result_valid cleared on result_valid && result_ready unless S_STORE writes the same edge; the store wins.
- abort (highest priority, any state): -> S_IDLE next edge, dac_code<=0, no result, no pulses; result_valid untouched.
- rst mid-conversion: full reset, pending result lost.
- soc outside S_IDLE ignored; rdy checked only at S_IDLE.

Decomposition:
- Shared encoding include: S_IDLE, S_SAMPLE, S_CONVERT, S_STORE encodings, MODE_SINGLE/MODE_SCAN/MODE_CONT constants.
- Sub-module adc_sar_reg: N-bit successive-approximation register with init, step (comp), nbits clamp and done flag. The FSM owns sequencing, channel and result logic.

Test Plan:
- N=8, mode 00, ch_first=2, nbits=8, sample_cycles=0, comparator model vin=0xA5; soc -> sample high 1 cycle, result=0xA5, result_ch=2, result_valid 10 cycles after soc, eoc_it one pulse, no eos_it.
- nbits=4, vin=0xA5 -> result=0xA0; nbits=0 -> clamps to 8, result=0xA5.
- mode 01, ch_first=3, ch_last=1, NCH=4 -> channels 3,0,1 converted in order; eos_it with channel 1 result; returns to S_IDLE.
- mode 10, result_ready held 0 -> second S_STORE pulses overrun, result holds newest code; result_ready=1 during S_STORE keeps result_valid=1.
- abort mid-S_CONVERT -> S_IDLE next cycle, dac_code=0, no eoc_it, previous result_valid unchanged; soc while busy ignored.
- enable low for 5 cycles mid-conversion -> state/dac_code frozen, final result identical to uninterrupted run; rst high in S_SAMPLE -> all outputs zero next edge.
